// File: rtl/cpu_action_scheduler.sv
// CPU opponent action scheduler: once per decision it picks idle, move left/right
// or attack from rnd_bits, holds the chosen button for a frame count, then cools down.
module cpu_action_scheduler #(
    parameter int unsigned HOLD_FRAMES     = 8,
    parameter int unsigned ATTACK_FRAMES   = 2,
    parameter int unsigned COOLDOWN_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       active,
    input  logic [3:0] rnd_bits,
    output logic       rnd_enable,
    output logic       btn_left,
    output logic       btn_right,
    output logic       btn_attack,
    output logic       busy,
    output logic [7:0] attack_count
);

    typedef enum logic [2:0] {
        IDLE,
        DECIDE,
        MOVE,
        ATTACK,
        COOLDOWN
    } state_e;

    localparam logic [7:0] HOLD_C   = 8'(HOLD_FRAMES);
    localparam logic [7:0] ATTACK_C = 8'(ATTACK_FRAMES);
    localparam logic [7:0] COOL_C   = 8'(COOLDOWN_FRAMES);
    localparam logic       DIR_LEFT = 1'b0;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       dir_q, dir_d;
    logic [7:0] attack_count_q, attack_count_d;

    // NOTE: async reset in the sensitivity list, and <= only, so every register updates together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            dir_q          <= DIR_LEFT;
            attack_count_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            dir_q          <= dir_d;
            attack_count_q <= attack_count_d;
        end
    end

    // NOTE: every signal gets its hold value first so no path through the case can infer a latch.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        dir_d          = dir_q;
        attack_count_d = attack_count_q;
        if (state_q != IDLE && !active) begin
            // Losing the round aborts whatever is in progress.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (active && frame_tick) state_d = DECIDE;
                end
                DECIDE: begin
                    // Any frame_tick in this cycle is deliberately ignored.
                    case (rnd_bits[1:0])
                        2'b00: begin
                            state_d = COOLDOWN;
                            cnt_d   = COOL_C;
                        end
                        2'b01, 2'b10: begin
                            state_d = MOVE;
                            dir_d   = rnd_bits[1];
                            cnt_d   = HOLD_C + {6'd0, rnd_bits[3:2]};
                        end
                        default: begin
                            state_d = ATTACK;
                            cnt_d   = ATTACK_C;
                            if (attack_count_q != 8'hFF) attack_count_d = attack_count_q + 8'd1;
                        end
                    endcase
                end
                MOVE, ATTACK: begin
                    if (frame_tick) begin
                        if (cnt_q == 8'd1) begin
                            state_d = COOLDOWN;
                            cnt_d   = COOL_C;
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end
                end
                COOLDOWN: begin
                    if (frame_tick) begin
                        if (cnt_q == 8'd1) state_d = DECIDE;
                        else               cnt_d   = cnt_q - 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rnd_enable   = (state_q == DECIDE);
    assign btn_left     = (state_q == MOVE) && (dir_q == DIR_LEFT);
    assign btn_right    = (state_q == MOVE) && (dir_q != DIR_LEFT);
    assign btn_attack   = (state_q == ATTACK);
    assign busy         = (state_q != IDLE);
    assign attack_count = attack_count_q;

endmodule

// File: tb/tb_cpu_action_scheduler.sv
// Scoreboard bench: each decision pushes the expected action profile, which is
// compared against observed frame counts when the next decision appears.
module tb_cpu_action_scheduler;

    localparam int HOLD = 8;
    localparam int ATK  = 2;
    localparam int COOL = 4;

    typedef struct packed {
        logic [7:0] left;
        logic [7:0] right;
        logic [7:0] atk;
        logic [7:0] cool;
    } act_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       active;
    logic [3:0] rnd_bits;
    logic       rnd_enable, btn_left, btn_right, btn_attack, busy;
    logic [7:0] attack_count;

    int         n_checks = 0;
    int         n_errors = 0;
    int         rnd_en_cycles = 0;
    int         period = 3;
    bit         rand_mode = 1'b0;
    bit         open = 1'b0;
    logic [7:0] model_atk = 8'd0;
    act_t       obs = '0;
    logic [3:0] stim_q[$];
    act_t       exp_q[$];

    cpu_action_scheduler #(
        .HOLD_FRAMES(HOLD),
        .ATTACK_FRAMES(ATK),
        .COOLDOWN_FRAMES(COOL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_tick(frame_tick),
        .active(active),
        .rnd_bits(rnd_bits),
        .rnd_enable(rnd_enable),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .btn_attack(btn_attack),
        .busy(busy),
        .attack_count(attack_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic act_t model(input logic [3:0] r);
        act_t e;
        e      = '0;
        e.cool = 8'(COOL);
        case (r[1:0])
            2'b01:   e.left  = 8'(HOLD + int'(r[3:2]));
            2'b10:   e.right = 8'(HOLD + int'(r[3:2]));
            2'b11:   e.atk   = 8'(ATK);
            default: ;
        endcase
        return e;
    endfunction

    // One clock: drive frame_tick, observe at the falling edge, return 1 ns after the rising edge.
    task automatic step(input logic tick);
        logic [3:0] s;
        act_t       e;
        frame_tick = tick;
        @(negedge clk);
        check("onehot", 32'($countones({btn_left, btn_right, btn_attack}) <= 1), 32'd1);
        if (rnd_enable) begin
            rnd_en_cycles++;
            if (open) begin
                e = exp_q.pop_front();
                check("action", obs, e);
            end
            check("attack_count", {24'd0, attack_count}, {24'd0, model_atk});
            if (stim_q.size() > 0) s = stim_q.pop_front();
            else if (rand_mode)    s = 4'($urandom);
            else                   s = 4'b0000;
            rnd_bits = s;
            exp_q.push_back(model(s));
            if (s[1:0] == 2'b11 && model_atk != 8'hFF) model_atk++;
            open = 1'b1;
            obs  = '0;
        end else if (tick) begin
            if (btn_left)        obs.left++;
            else if (btn_right)  obs.right++;
            else if (btn_attack) obs.atk++;
            else if (busy)       obs.cool++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        step(1'b1);
        for (int i = 1; i < period; i++) step(1'b0);
    endtask

    // Run until every queued stimulus has been decided on and its action compared.
    task automatic drain(input int budget);
        int target;
        int b;
        target = rnd_en_cycles + stim_q.size() + 1;
        b = 0;
        while (rnd_en_cycles < target && b < budget) begin
            frame();
            b++;
        end
        check("drain_timeout", 32'(rnd_en_cycles >= target), 32'd1);
    endtask

    task automatic abort(input string tag);
        int r0;
        if (rnd_enable) step(1'b0);
        active = 1'b0;
        step(1'b0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_btns"}, {29'd0, btn_left, btn_right, btn_attack}, 32'd0);
        exp_q.delete();
        open = 1'b0;
        r0 = rnd_en_cycles;
        repeat (5) frame();
        check({tag, "_no_decide"}, rnd_en_cycles, r0);
        active = 1'b1;
        repeat (3) step(1'b0);
        check({tag, "_no_tick_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int b;
        rst        = 1'b1;
        active     = 1'b0;
        frame_tick = 1'b0;
        rnd_bits   = 4'b0000;
        #2;
        check("reset_outputs", {19'd0, rnd_enable, btn_left, btn_right, btn_attack, busy, attack_count}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_held", {19'd0, rnd_enable, btn_left, btn_right, btn_attack, busy, attack_count}, 32'd0);
        rst    = 1'b0;
        active = 1'b1;
        repeat (4) step(1'b0);
        check("wait_first_tick", {31'd0, busy}, 32'd0);

        // Directed actions: left 9, attack 2, right 9, right 10, idle, left 11.
        stim_q = '{4'b0101, 4'b1111, 4'b0110, 4'b1010, 4'b0000, 4'b1101};
        drain(300);

        // Abort in the third frame of a right move.
        stim_q.push_back(4'b0110);
        b = 0;
        while (!btn_right && b < 100) begin
            frame();
            b++;
        end
        check("right_seen", {31'd0, btn_right}, 32'd1);
        frame();
        frame();
        check("right_held", {31'd0, btn_right}, 32'd1);
        abort("abort_move");

        // Saturation, then a left move with frame_tick in the decision cycle.
        period = 1;
        repeat (300) stim_q.push_back(4'b0011);
        stim_q.push_back(4'b0101);
        drain(5000);
        check("attack_sat", {24'd0, attack_count}, 32'd255);

        // Asynchronous reset in the middle of a move.
        period = 3;
        stim_q.push_back(4'b0101);
        b = 0;
        while (!btn_left && b < 100) begin
            frame();
            b++;
        end
        frame();
        check("left_before_rst", {31'd0, btn_left}, 32'd1);
        #3 rst = 1'b1;
        #1;
        check("rst_async", {19'd0, rnd_enable, btn_left, btn_right, btn_attack, busy, attack_count}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stim_q.delete();
        exp_q.delete();
        open      = 1'b0;
        model_atk = 8'd0;
        repeat (3) step(1'b0);
        check("post_rst_idle", {31'd0, busy}, 32'd0);

        // Random soak with periodic aborts.
        rand_mode = 1'b1;
        period    = 2;
        for (int k = 0; k < 6; k++) begin
            repeat (400) frame();
            abort("soak_abort");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
